// File: rtl/instr_decode_queue.sv
// Instruction queue that decodes each accepted word into its control-state number
// at push time and presents the head entry (word + state) to the consumer.
module instr_decode_queue #(
    parameter int STATE_W     = 10,
    parameter int DEPTH       = 4,
    parameter int FETCH_STATE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              instruction,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [STATE_W-1:0]       state_number,
    output logic [31:0]              out_instruction,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]        word_mem  [DEPTH];
    logic [STATE_W-1:0] state_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               pop;

    // Load/store state: base picked by {B,U}, then +0/+2/+post step for offset/pre/post.
    // Register-offset codes sit one above immediate ones and post-index steps by 6, not 4.
    function automatic logic [7:0] ls_code(input logic [31:0] ins, input logic reg_form);
        logic [7:0] base;
        logic [7:0] step;
        case ({ins[22], ins[23]})
            2'b11:   base = 8'd20;
            2'b10:   base = 8'd30;
            2'b01:   base = 8'd43;
            default: base = 8'd53;
        endcase
        if (!ins[24])
            step = reg_form ? 8'd6 : 8'd4;
        else if (ins[21])
            step = 8'd2;
        else
            step = 8'd0;
        ls_code = base + step + (reg_form ? 8'd1 : 8'd0) + (ins[20] ? 8'd100 : 8'd0);
    endfunction

    function automatic logic [STATE_W-1:0] decode_state(input logic [31:0] ins);
        logic [STATE_W-1:0] res;
        res = STATE_W'(FETCH_STATE);
        case (ins[27:25])
            3'b000, 3'b001: res = ins[20] ? STATE_W'(10) : STATE_W'(11);
            3'b101:         res = ins[24] ? STATE_W'(13) : STATE_W'(12);
            3'b010:         res = STATE_W'(ls_code(ins, 1'b0));
            3'b011:         if (!ins[4]) res = STATE_W'(ls_code(ins, 1'b1));
            default:        res = STATE_W'(FETCH_STATE);
        endcase
        decode_state = res;
    endfunction

    assign in_ready  = (count < CNT_W'(DEPTH)) && !flush && !reset;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointers and occupancy; reset outranks flush, flush drops the cycle's push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Storage is never cleared; push is already gated off during reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr]  <= instruction;
            state_mem[wr_ptr] <= decode_state(instruction);
        end
    end

    assign state_number    = out_valid ? state_mem[rd_ptr] : STATE_W'(FETCH_STATE);
    assign out_instruction = out_valid ? word_mem[rd_ptr]  : 32'd0;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: decode values, FIFO order, full/wrap,
// simultaneous push/pop, flush and reset behaviour with hand-computed expectations.
module tb_instr_decode_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  state_number;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    instr_decode_queue #(.STATE_W(10), .DEPTH(4), .FETCH_STATE(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .instruction     (instruction),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .state_number    (state_number),
        .out_instruction (out_instruction),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it; inputs are then changed away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid    = 1'b1;
        instruction = w;
        step();
        in_valid    = 1'b0;
        #1;
    endtask

    logic [31:0] fill_words [5];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_state", 32'(state_number), 32'd1);
        chk("rst_instr", out_instruction, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // STRB immediate offset, add -> 20, one-cycle latency
        out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hE5C21004;
        #1;
        chk("strb_pre_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        #1;
        chk("strb_valid", 32'(out_valid), 32'd1);
        chk("strb_state", 32'(state_number), 32'd20);
        chk("strb_instr", out_instruction, 32'hE5C21004);
        chk("strb_count1", 32'(count), 32'd1);
        step();
        chk("strb_count0", 32'(count), 32'd0);
        chk("strb_drained", 32'(out_valid), 32'd0);

        // LDR post-indexed subtract, ADDS, BL in order
        out_ready = 1'b0;
        push_word(32'hE4121004);
        push_word(32'hE0910002);
        push_word(32'hEB000010);
        chk("three_count", 32'(count), 32'd3);
        chk("ldr_state_hold", 32'(state_number), 32'd157);
        step();
        chk("ldr_state_stable", 32'(state_number), 32'd157);
        out_ready = 1'b1;
        #1;
        chk("ldr_state", 32'(state_number), 32'd157);
        step();
        chk("adds_state", 32'(state_number), 32'd10);
        step();
        chk("bl_state", 32'(state_number), 32'd13);
        step();
        chk("three_empty", 32'(count), 32'd0);

        // Fill past DEPTH with out_ready low, then drain across the pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) fill_words[i] = 32'hE0800000 + 32'(i);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; instruction = fill_words[i];
            #1;
            chk($sformatf("fill_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_instr%0d", i), out_instruction, fill_words[i]);
            chk($sformatf("drain_state%0d", i), 32'(state_number), 32'd11);
            step();
        end
        chk("drain_count", 32'(count), 32'd0);

        // Simultaneous push and pop keeps count
        out_ready = 1'b0;
        push_word(32'hE5C21004);
        out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hEB000010;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pushpop_count", 32'(count), 32'd1);
        chk("pushpop_head", out_instruction, 32'hEB000010);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Register offset with bit4 set, and SWI, both fall back to fetch
        push_word(32'hE7821013);
        push_word(32'hEF000000);
        chk("regbit4_state", 32'(state_number), 32'd1);
        chk("regbit4_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("swi_state", 32'(state_number), 32'd1);
        chk("swi_instr", out_instruction, 32'hEF000000);
        step();
        out_ready = 1'b0;

        // Register-offset store, word add, pre-indexed: 0xE7A21003 -> 46
        push_word(32'hE7A21003);
        chk("reg_pre_state", 32'(state_number), 32'd46);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush at count 3 with a push offered
        push_word(32'hE0800001);
        push_word(32'hE0800002);
        push_word(32'hE0800003);
        chk("preflush_count", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; instruction = 32'hEB000010;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_state", 32'(state_number), 32'd1);
        push_word(32'hE0910002);
        chk("postflush_head", out_instruction, 32'hE0910002);
        chk("postflush_count", 32'(count), 32'd1);

        // Reset mid-stream at count 2, then a normal push
        push_word(32'hE5C21004);
        chk("prereset_count", 32'(count), 32'd2);
        reset = 1'b1; in_valid = 1'b1; instruction = 32'hEB000010;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_state", 32'(state_number), 32'd1);
        chk("reset_instr", out_instruction, 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        push_word(32'hE0910002);
        chk("postreset_count", 32'(count), 32'd1);
        chk("postreset_state", 32'(state_number), 32'd10);
        chk("postreset_instr", out_instruction, 32'hE0910002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
